// File: rtl/line_scanout_pkg.sv
// Shared defaults and scan FSM encoding for the ping-pong scanline buffer.
package line_scanout_pkg;

    localparam int         H_ACTIVE_DEF = 640;
    localparam int         IDX_W_DEF    = 4;
    localparam logic [3:0] TRANSP_DEF   = 4'd0;
    localparam logic [3:0] BG_INDEX_DEF = 4'd1;

    localparam int X_W    = 10;
    localparam int RAM_AW = X_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/line_scanout_bank_ram.sv
// Two line banks in one simple dual-port RAM, addressed {bank, x}.
// Read data is registered (1 cycle); no backpressure, contents are never reset.
module line_bank_ram
    import line_scanout_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic              Clk50,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [IDX_W-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [IDX_W-1:0]  rd_dat
);

    logic [IDX_W-1:0] mem [2**RAM_AW];

    always_ff @(posedge Clk50) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/line_scanout.sv
// Ping-pong scanline buffer: renderer fills the back bank, VGA side streams the front bank.
// Pixel x reaches pix_index two Clk50 after it is addressed; no backpressure, late renders flag underrun.
module line_scanout
    import line_scanout_pkg::*;
#(
    parameter int               H_ACTIVE = H_ACTIVE_DEF,
    parameter int               IDX_W    = IDX_W_DEF,
    parameter logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSP_DEF),
    parameter logic [IDX_W-1:0] BG_INDEX = IDX_W'(BG_INDEX_DEF)
) (
    input  logic             Clk50,
    input  logic             Reset,
    input  logic             pix_ce,
    input  logic             line_start,
    input  logic             line_vis,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x,
    input  logic [IDX_W-1:0] wr_index,
    input  logic             wr_done,
    output logic             render_req,
    output logic [IDX_W-1:0] pix_index,
    output logic             pix_valid,
    output logic             underrun
);

    localparam logic [X_W-1:0] X_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);

    scan_state_t      state, state_nxt;
    logic [X_W-1:0]   x_cnt;
    logic             front_sel, busy, primed, back_ready, rd_pend;
    logic             rd_en, x_clr;
    logic [IDX_W-1:0] rd_dat;

    logic vis_start, busy_eff, ready_eff, start_render, swap, wr_ok;

    // A wr_done landing on line_start counts as finished before the swap decision.
    assign vis_start    = line_start & line_vis;
    assign busy_eff     = busy & ~wr_done;
    assign ready_eff    = back_ready | (busy & wr_done);
    assign start_render = vis_start & ~busy_eff;
    assign swap         = start_render & ready_eff;
    assign wr_ok        = wr_en & busy & (wr_x < X_END);

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, HOLD: if (vis_start) state_nxt = SCAN;
            SCAN:       if (pix_ce && x_cnt == X_LAST) state_nxt = HOLD;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state == SCAN) & pix_ce;
        x_clr = (state != SCAN) & vis_start;
    end

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset)      x_cnt <= '0;
        else if (x_clr) x_cnt <= '0;
        else if (rd_en) x_cnt <= x_cnt + 1'b1;
    end

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            front_sel  <= 1'b0;
            busy       <= 1'b0;
            back_ready <= 1'b0;
            primed     <= 1'b0;
            render_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            render_req <= start_render;
            if (swap) begin
                front_sel <= ~front_sel;
                primed    <= 1'b1;
            end
            if (start_render) begin
                busy       <= 1'b1;
                back_ready <= 1'b0;
            end else if (busy && wr_done) begin
                busy       <= 1'b0;
                back_ready <= 1'b1;
            end
            if (vis_start && busy_eff && primed) underrun <= 1'b1;
        end
    end

    line_bank_ram #(.IDX_W(IDX_W)) u_ram (
        .Clk50   (Clk50),
        .wr_en   (wr_ok),
        .wr_addr ({~front_sel, wr_x}),
        .wr_dat  (wr_index),
        .rd_en   (rd_en),
        .rd_addr ({front_sel, x_cnt}),
        .rd_dat  (rd_dat)
    );

    function automatic logic [IDX_W-1:0] to_palette(input logic [IDX_W-1:0] idx, input logic show);
        return (!show || idx == TRANSP) ? BG_INDEX : idx;
    endfunction

    // rd_pend marks that the RAM register holds a pixel addressed on the previous pix_ce.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            rd_pend   <= 1'b0;
            pix_valid <= 1'b0;
            pix_index <= BG_INDEX;
        end else if (pix_ce) begin
            rd_pend   <= rd_en;
            pix_valid <= rd_pend;
            pix_index <= rd_pend ? to_palette(rd_dat, primed) : BG_INDEX;
        end
    end

endmodule

// File: tb/tb_line_scanout.sv
// Line-level stimulus table with a behavioural bank model feeding a pixel scoreboard.
module tb_line_scanout;
    import line_scanout_pkg::*;

    localparam int HA      = 640;
    localparam int LINE    = 1400;
    localparam int W_START = 4;
    localparam int DONE_AT = 650;
    localparam int LATE_AT = 660;
    localparam int LATE_N  = 64;
    localparam int OOR_N   = 384;
    localparam int NROWS   = 13;
    localparam logic [3:0] BG = 4'd1;
    localparam logic [3:0] TR = 4'd0;

    logic       Clk50, Reset, pix_ce, line_start, line_vis, wr_en, wr_done;
    logic [9:0] wr_x;
    logic [3:0] wr_index;
    logic       render_req, pix_valid, underrun;
    logic [3:0] pix_index;

    line_scanout dut (
        .Clk50      (Clk50),
        .Reset      (Reset),
        .pix_ce     (pix_ce),
        .line_start (line_start),
        .line_vis   (line_vis),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_index   (wr_index),
        .wr_done    (wr_done),
        .render_req (render_req),
        .pix_index  (pix_index),
        .pix_valid  (pix_valid),
        .underrun   (underrun)
    );

    initial begin
        Clk50 = 1'b0;
        forever #5 Clk50 = ~Clk50;
    end

    // wpat: 0 none, 1 constant val, 2 x mod 16, 3 val at x = 640..1023
    // done: 0 withheld, 1 inside the line, 2 coincident with the next line_start
    typedef struct {
        bit         vis;
        int         wpat;
        logic [3:0] val;
        int         done;
        bit         late;
        bit         rst;
        bit         exp_req;
        bit         exp_under;
    } row_t;

    row_t tbl [NROWS];

    int n_chk = 0;
    int n_pass = 0;
    int vld_cnt = 0;
    int req_cnt = 0;
    bit pend_done;

    logic [3:0] bank [2][HA];
    bit m_busy, m_primed, m_ready, m_front, m_under;
    logic [3:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_primed = 0; m_ready = 0; m_front = 0; m_under = 0;
        exp_q.delete();
        pend_done = 0;
    endtask

    task automatic model_apply();
        logic [3:0] v;
        if (wr_en && m_busy && wr_x < 10'd640) bank[m_front ^ 1'b1][wr_x] = wr_index;
        if (wr_done && m_busy) begin
            m_busy  = 0;
            m_ready = 1;
        end
        if (line_start && line_vis) begin
            if (!m_busy) begin
                if (m_ready) begin
                    m_front  = m_front ^ 1'b1;
                    m_primed = 1;
                    m_ready  = 0;
                end
                m_busy = 1;
            end else if (m_primed) begin
                m_under = 1;
            end
            for (int x = 0; x < HA; x++) begin
                v = bank[m_front][x];
                exp_q.push_back((!m_primed || v == TR) ? BG : v);
            end
        end
    endtask

    task automatic step();
        if (!Reset) model_apply();
        @(posedge Clk50);
        #1;
        pix_ce     = ~pix_ce;
        line_start = 0;
        line_vis   = 0;
        wr_en      = 0;
        wr_done    = 0;
    endtask

    task automatic run_line(input row_t r, input int idx);
        if (!pix_ce) step();
        vld_cnt = 0;
        req_cnt = 0;
        for (int c = 0; c < LINE; c++) begin
            if (c == 0) begin
                line_start = 1;
                line_vis   = r.vis;
                wr_done    = pend_done;
                pend_done  = 0;
            end
            if (r.wpat != 0 && c >= W_START && c < W_START + HA) begin
                wr_en = 1;
                case (r.wpat)
                    1: begin wr_x = 10'(c - W_START); wr_index = r.val; end
                    2: begin wr_x = 10'(c - W_START); wr_index = wr_x[3:0]; end
                    default: begin wr_x = 10'(HA + ((c - W_START) % OOR_N)); wr_index = r.val; end
                endcase
            end
            if (r.done == 1 && c == DONE_AT) wr_done = 1;
            if (r.late && c >= LATE_AT && c < LATE_AT + LATE_N) begin
                wr_en    = 1;
                wr_x     = 10'(c - LATE_AT);
                wr_index = 4'd7;
            end
            step();
            if (c == 0) chk($sformatf("row%0d_render_req_next_cycle", idx), render_req, r.exp_req);
        end
        if (r.done == 2) pend_done = 1;
        chk($sformatf("row%0d_render_req_pulses", idx), req_cnt, r.exp_req ? 1 : 0);
        chk($sformatf("row%0d_valid_pixels", idx), vld_cnt, r.vis ? HA : 0);
        chk($sformatf("row%0d_pixels_left", idx), exp_q.size(), 0);
        chk($sformatf("row%0d_underrun", idx), underrun, r.exp_under);
    endtask

    // Visible line with the renderer still busy, reset lands just after x = 300 is addressed.
    task automatic reset_mid_line();
        if (!pix_ce) step();
        line_start = 1;
        line_vis   = 1;
        step();
        repeat (2 + 2 * 300) step();
        chk("pre_reset_pix_valid", pix_valid, 1);
        chk("pre_reset_underrun", underrun, 1);
        Reset = 1;
        #1;
        chk("mid_reset_pix_valid", pix_valid, 0);
        chk("mid_reset_pix_index", pix_index, BG);
        chk("mid_reset_render_req", render_req, 0);
        chk("mid_reset_underrun", underrun, 0);
        model_reset();
        repeat (3) step();
        Reset = 0;
        repeat (4) step();
        chk("post_reset_pix_valid", pix_valid, 0);
    endtask

    initial begin : monitor
        bit ce_s;
        forever begin
            @(posedge Clk50);
            ce_s = pix_ce;
            #2;
            if (render_req) req_cnt++;
            if (!Reset && ce_s && pix_valid) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pix_extra: got index %0d with no pixel expected", pix_index);
                end else begin
                    chk("pix_index", pix_index, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        Reset = 1; pix_ce = 0; line_start = 0; line_vis = 0;
        wr_en = 0; wr_x = '0; wr_index = '0; wr_done = 0;
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < HA; x++) bank[b][x] = 4'd0;
        model_reset();

        //          vis wpat val   done late rst req under
        tbl[0]  = '{1, 1, 4'd5,  1, 0, 0, 1, 0};  // first line: render_req, BG only
        tbl[1]  = '{1, 1, 4'd5,  1, 0, 0, 1, 0};  // 5s
        tbl[2]  = '{1, 2, 4'd0,  1, 0, 0, 1, 0};  // 5s, pattern rendered
        tbl[3]  = '{1, 1, 4'd6,  2, 0, 0, 1, 0};  // pattern, done deferred
        tbl[4]  = '{1, 3, 4'd11, 1, 1, 0, 1, 0};  // coincident done -> 6s, dropped writes
        tbl[5]  = '{1, 1, 4'd9,  0, 0, 0, 1, 0};  // pattern intact, done withheld
        tbl[6]  = '{1, 1, 4'd3,  1, 0, 0, 0, 1};  // underrun, pattern repeated
        tbl[7]  = '{0, 0, 4'd0,  0, 0, 0, 0, 1};  // invisible line
        tbl[8]  = '{1, 0, 4'd0,  0, 0, 0, 1, 1};  // 3s
        tbl[9]  = '{1, 0, 4'd0,  0, 0, 1, 0, 0};  // reset mid-scan
        tbl[10] = '{1, 1, 4'd5,  1, 0, 0, 1, 0};  // first line after reset
        tbl[11] = '{1, 2, 4'd0,  1, 0, 0, 1, 0};  // 5s
        tbl[12] = '{1, 0, 4'd0,  0, 0, 0, 1, 0};  // pattern

        repeat (3) @(posedge Clk50);
        #1;
        chk("reset_pix_index", pix_index, BG);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_render_req", render_req, 0);
        chk("reset_underrun", underrun, 0);
        Reset = 0;
        repeat (2) step();

        for (int i = 0; i < NROWS; i++) begin
            if (tbl[i].rst) reset_mid_line();
            else            run_line(tbl[i], i);
        end

        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
